// File: rtl/l3_hdr_rx.sv
// rtl/l3_hdr_rx.sv - L3 header receiver and payload splitter
//
// Assembles the 6-byte L3 header (ID, opcode, extend[15:0], size[15:0]) from
// the layer-2 byte stream. It presents the header with a one-cycle l3_en
// strobe and forwards the payload bytes that follow on wr_vld/wr_data.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   clr_core       synchronous clear, same effect as reset
//   dev_id         device ID compared with ID-byte lower nibble
//   l2_sof/l2_vld/l2_data/l2_eof   layer-2 byte stream with frame markers
//   l3_en          one-cycle header-complete strobe
//   l3_op, l3_extend, l3_size, core_sel, id_err   held header fields
//   wr_vld, wr_data   payload byte strobe and byte
//   hdr_err        pulse: frame ended before header complete
//   len_err        pulse: payload count differed from l3_size at EOF
module l3_hdr_rx #(
    parameter logic [3:0] CORE_GRP = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_core,
    input  logic [3:0]  dev_id,
    input  logic        l2_sof,
    input  logic        l2_vld,
    input  logic [7:0]  l2_data,
    input  logic        l2_eof,
    output logic        l3_en,
    output logic [7:0]  l3_op,
    output logic [15:0] l3_extend,
    output logic [15:0] l3_size,
    output logic        core_sel,
    output logic        id_err,
    output logic        wr_vld,
    output logic [7:0]  wr_data,
    output logic        hdr_err,
    output logic        len_err
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  hdr_idx_q;
    logic [15:0] rem_q, rem_d;
    logic        ovf_q, ovf_d;

    // Shadow copies of a header still being received
    logic [7:0]  op_sh_q;
    logic [15:0] ext_sh_q;
    logic [7:0]  size_hi_sh_q;
    logic        sel_sh_q;
    logic        ierr_sh_q;

    logic        l3_en_q, core_sel_q, id_err_q, wr_vld_q, hdr_err_q, len_err_q;
    logic [7:0]  l3_op_q, wr_data_q;
    logic [15:0] l3_extend_q, l3_size_q;

    logic        hdr_last;
    logic [15:0] size_full;
    logic        id_sel, id_mis;
    logic        close_hdr_err, close_len_err;

    assign size_full = {size_hi_sh_q, l2_data};
    assign hdr_last  = (state_q == HDR) && l2_vld && (hdr_idx_q == 3'd5);
    assign id_sel    = (l2_data[7:4] == CORE_GRP);
    assign id_mis    = (l2_data[3:0] != dev_id);

    // Frame state after this cycle's byte has been consumed, before any EOF.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            HDR: begin
                if (hdr_last) begin
                    rem_d   = size_full;
                    state_d = (size_full != 16'd0) ? PAYLOAD : DROP;
                end
            end
            PAYLOAD: begin
                if (l2_vld) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (l2_vld) begin
                    ovf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Status of the frame being closed. With a coincident SOF the same-cycle
    // byte belongs to the new frame, so the old frame is judged as it stood.
    always_comb begin
        close_hdr_err = 1'b0;
        close_len_err = 1'b0;
        if (l2_sof) begin
            close_hdr_err = (state_q == HDR);
            close_len_err = (state_q == PAYLOAD) || ((state_q == DROP) && ovf_q);
        end else begin
            close_hdr_err = (state_d == HDR);
            close_len_err = (state_d == PAYLOAD) || ((state_d == DROP) && ovf_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_idx_q    <= 3'd0;
            rem_q        <= 16'd0;
            ovf_q        <= 1'b0;
            op_sh_q      <= 8'd0;
            ext_sh_q     <= 16'd0;
            size_hi_sh_q <= 8'd0;
            sel_sh_q     <= 1'b0;
            ierr_sh_q    <= 1'b0;
            l3_en_q      <= 1'b0;
            l3_op_q      <= 8'd0;
            l3_extend_q  <= 16'd0;
            l3_size_q    <= 16'd0;
            core_sel_q   <= 1'b0;
            id_err_q     <= 1'b0;
            wr_vld_q     <= 1'b0;
            wr_data_q    <= 8'd0;
            hdr_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
        end else if (clr_core) begin
            state_q      <= IDLE;
            hdr_idx_q    <= 3'd0;
            rem_q        <= 16'd0;
            ovf_q        <= 1'b0;
            op_sh_q      <= 8'd0;
            ext_sh_q     <= 16'd0;
            size_hi_sh_q <= 8'd0;
            sel_sh_q     <= 1'b0;
            ierr_sh_q    <= 1'b0;
            l3_en_q      <= 1'b0;
            l3_op_q      <= 8'd0;
            l3_extend_q  <= 16'd0;
            l3_size_q    <= 16'd0;
            core_sel_q   <= 1'b0;
            id_err_q     <= 1'b0;
            wr_vld_q     <= 1'b0;
            wr_data_q    <= 8'd0;
            hdr_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            l3_en_q   <= 1'b0;
            wr_vld_q  <= 1'b0;
            hdr_err_q <= 1'b0;
            len_err_q <= 1'b0;

            if (l2_sof) begin
                // Close any open frame (errors only on a coincident EOF),
                // then restart header collection.
                hdr_err_q <= l2_eof && close_hdr_err;
                len_err_q <= l2_eof && close_len_err;
                state_q   <= HDR;
                rem_q     <= 16'd0;
                ovf_q     <= 1'b0;
                if (l2_vld) begin
                    sel_sh_q  <= id_sel;
                    ierr_sh_q <= id_mis;
                    hdr_idx_q <= 3'd1;
                end else begin
                    hdr_idx_q <= 3'd0;
                end
            end else begin
                if (l2_eof) begin
                    state_q   <= IDLE;
                    rem_q     <= 16'd0;
                    ovf_q     <= 1'b0;
                    hdr_idx_q <= 3'd0;
                    hdr_err_q <= close_hdr_err;
                    len_err_q <= close_len_err;
                end else begin
                    state_q <= state_d;
                    rem_q   <= rem_d;
                    ovf_q   <= ovf_d;
                    if (hdr_last) begin
                        hdr_idx_q <= 3'd0;
                    end else if ((state_q == HDR) && l2_vld) begin
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                    end
                end

                if ((state_q == HDR) && l2_vld) begin
                    case (hdr_idx_q)
                        3'd0: begin
                            sel_sh_q  <= id_sel;
                            ierr_sh_q <= id_mis;
                        end
                        3'd1: op_sh_q        <= l2_data;
                        3'd2: ext_sh_q[15:8] <= l2_data;
                        3'd3: ext_sh_q[7:0]  <= l2_data;
                        3'd4: size_hi_sh_q   <= l2_data;
                        3'd5: begin
                            // Header complete: publish shadows to outputs
                            l3_en_q     <= 1'b1;
                            l3_op_q     <= op_sh_q;
                            l3_extend_q <= ext_sh_q;
                            l3_size_q   <= size_full;
                            core_sel_q  <= sel_sh_q;
                            id_err_q    <= ierr_sh_q;
                        end
                        default: ;
                    endcase
                end

                if ((state_q == PAYLOAD) && l2_vld) begin
                    wr_vld_q  <= 1'b1;
                    wr_data_q <= l2_data;
                end
            end
        end
    end

    assign l3_en     = l3_en_q;
    assign l3_op     = l3_op_q;
    assign l3_extend = l3_extend_q;
    assign l3_size   = l3_size_q;
    assign core_sel  = core_sel_q;
    assign id_err    = id_err_q;
    assign wr_vld    = wr_vld_q;
    assign wr_data   = wr_data_q;
    assign hdr_err   = hdr_err_q;
    assign len_err   = len_err_q;

endmodule
